// File: rtl/char_action_sequencer.sv
// char_action_sequencer
// Frame-paced character state machine: arbitrates movement vs. attacks and walks each attack
// through startup / active / recovery phases with per-phase frame counts.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   frame_tick  one-clk pulse per video frame; state and counter only advance on it
//   btn_left    left button level (synchronized, debounced)
//   btn_right   right button level (synchronized, debounced)
//   btn_attack  attack button level (synchronized, debounced)
//   state       character state code (IDLE=0 .. DIR_RECOVERY=8)
//   frame_cnt   frames already spent in the current attack phase, 0 outside attacks
//   hit_active  high in either active phase
//   busy        high in any attack state
module char_action_sequencer #(
  parameter int unsigned START_FRAMES        = 5,
  parameter int unsigned ACTIVE_FRAMES       = 2,
  parameter int unsigned RECOVERY_FRAMES     = 16,
  parameter int unsigned DIR_START_FRAMES    = 4,
  parameter int unsigned DIR_ACTIVE_FRAMES   = 3,
  parameter int unsigned DIR_RECOVERY_FRAMES = 15,
  parameter int unsigned CNT_W               = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_attack,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             hit_active,
  output logic             busy
);

  typedef enum logic [3:0] {
    StIdle        = 4'd0,
    StLeft        = 4'd1,
    StRight       = 4'd2,
    StAtkStart    = 4'd3,
    StAtkActive   = 4'd4,
    StAtkRecovery = 4'd5,
    StDirStart    = 4'd6,
    StDirActive   = 4'd7,
    StDirRecovery = 4'd8
  } state_e;

  // Last counter value of each phase (N-1).
  localparam logic [CNT_W-1:0] StartLast     = CNT_W'(START_FRAMES - 1);
  localparam logic [CNT_W-1:0] ActiveLast    = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] RecoveryLast  = CNT_W'(RECOVERY_FRAMES - 1);
  localparam logic [CNT_W-1:0] DStartLast    = CNT_W'(DIR_START_FRAMES - 1);
  localparam logic [CNT_W-1:0] DActiveLast   = CNT_W'(DIR_ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] DRecoveryLast = CNT_W'(DIR_RECOVERY_FRAMES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             atk_q;
  logic             hit_q, hit_d;
  logic             busy_q, busy_d;

  logic             atk_rise, atk_req, one_dir, idle_like, in_atk;
  logic [CNT_W-1:0] last;
  state_e           nxt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    idle_like = 1'b0;
    in_atk    = 1'b0;
    last      = '0;
    nxt       = StIdle;
    atk_rise  = btn_attack & ~atk_q;
    atk_req   = pending_q | atk_rise;
    one_dir   = btn_left ^ btn_right;

    case (state_q)
      StIdle, StLeft, StRight: idle_like = 1'b1;
      StAtkStart:    begin in_atk = 1'b1; last = StartLast;     nxt = StAtkActive;   end
      StAtkActive:   begin in_atk = 1'b1; last = ActiveLast;    nxt = StAtkRecovery; end
      StAtkRecovery: begin in_atk = 1'b1; last = RecoveryLast;  nxt = StIdle;        end
      StDirStart:    begin in_atk = 1'b1; last = DStartLast;    nxt = StDirActive;   end
      StDirActive:   begin in_atk = 1'b1; last = DActiveLast;   nxt = StDirRecovery; end
      StDirRecovery: begin in_atk = 1'b1; last = DRecoveryLast; nxt = StIdle;        end
      default: begin
        // Illegal code: recover on the very next clk, tick or not.
        state_d   = StIdle;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    // Edges while busy are dropped rather than buffered into a later attack.
    if (idle_like && atk_rise) pending_d = 1'b1;

    if (frame_tick && idle_like) begin
      pending_d = 1'b0;
      cnt_d     = '0;
      if (atk_req)                      state_d = one_dir ? StDirStart : StAtkStart;
      else if (btn_left && !btn_right)  state_d = StLeft;
      else if (btn_right && !btn_left)  state_d = StRight;
      else                              state_d = StIdle;
    end

    if (frame_tick && in_atk) begin
      if (cnt_q == last) begin
        state_d = nxt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Flags are registered alongside state so they come straight from flops.
    busy_d = (state_d >= StAtkStart) && (state_d <= StDirRecovery);
    hit_d  = (state_d == StAtkActive) || (state_d == StDirActive);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      atk_q     <= 1'b0;
      hit_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      atk_q     <= btn_attack;
      hit_q     <= hit_d;
      busy_q    <= busy_d;
    end
  end

  assign state      = state_q;
  assign frame_cnt  = cnt_q;
  assign hit_active = hit_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_char_action_sequencer.sv
// Directed self-checking bench for char_action_sequencer. A second instance with all phase
// lengths set to 1 shares the stimulus and is checked during the first neutral attack.
module tb_char_action_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_attack = 1'b0;
  logic [3:0] state, state1;
  logic [4:0] frame_cnt, frame_cnt1;
  logic       hit_active, hit_active1;
  logic       busy, busy1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  char_action_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_attack (btn_attack),
    .state      (state),
    .frame_cnt  (frame_cnt),
    .hit_active (hit_active),
    .busy       (busy)
  );

  char_action_sequencer #(
    .START_FRAMES        (1),
    .ACTIVE_FRAMES       (1),
    .RECOVERY_FRAMES     (1),
    .DIR_START_FRAMES    (1),
    .DIR_ACTIVE_FRAMES   (1),
    .DIR_RECOVERY_FRAMES (1),
    .CNT_W               (5)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_attack (btn_attack),
    .state      (state1),
    .frame_cnt  (frame_cnt1),
    .hit_active (hit_active1),
    .busy       (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_tick pulse; returns at the following negedge so outputs are settled.
  task automatic tick(input logic atk_with_tick = 1'b0);
    @(negedge clk);
    frame_tick = 1'b1;
    if (atk_with_tick) btn_attack = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic check_st(input string tag, input int st, input int cnt, input int hit,
                          input int bsy);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".cnt"}, 32'(frame_cnt), 32'(cnt));
    check({tag, ".hit"}, 32'(hit_active), 32'(hit));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic pulse_attack();
    @(negedge clk);
    btn_attack = 1'b1;
    @(negedge clk);
    btn_attack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset, with a tick while held that must be ignored.
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    btn_right  = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    btn_right  = 1'b0;
    check_st("reset", 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Movement.
    btn_right = 1'b1;
    @(negedge clk);
    check("move.no_tick", 32'(state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_st("move.right", 2, 0, 0, 0);
    end
    repeat (3) @(negedge clk);
    check("move.hold", 32'(state), 32'd2);
    btn_left = 1'b1;
    tick();
    check_st("move.both", 0, 0, 0, 0);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    tick();
    check_st("move.none", 0, 0, 0, 0);

    // Neutral attack from a pulse between ticks; unit-length instance checked alongside.
    pulse_attack();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_st("neu.start", 3, i, 0, 1);
      if (i == 0) check("p1.s3", 32'(state1), 32'd3);
      if (i == 1) check("p1.s4", 32'(state1), 32'd4);
      if (i == 1) check("p1.hit", 32'(hit_active1), 32'd1);
      if (i == 2) check("p1.s5", 32'(state1), 32'd5);
      if (i < 3)  check("p1.cnt", 32'(frame_cnt1), 32'd0);
      if (i == 3) check("p1.s0", 32'(state1), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check_st("neu.active", 4, i, 1, 1);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      check_st("neu.recov", 5, i, 0, 1);
    end
    tick();
    check_st("neu.end", 0, 0, 0, 0);

    // Directional attack, edge coincident with the tick.
    btn_left = 1'b1;
    @(negedge clk);
    tick(1'b1);
    check_st("dir.start0", 6, 0, 0, 1);
    btn_attack = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_st("dir.start", 6, i, 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check_st("dir.active", 7, i, 1, 1);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      check_st("dir.recov", 8, i, 0, 1);
    end
    tick();
    check_st("dir.end", 0, 0, 0, 0);
    tick();
    check_st("dir.resume", 1, 0, 0, 0);
    btn_left = 1'b0;
    tick();
    check("dir.idle", 32'(state), 32'd0);

    // Edge during active is discarded; held button must not retrigger later.
    pulse_attack();
    repeat (6) tick();
    check_st("disc.active", 4, 0, 1, 1);
    btn_attack = 1'b1;
    tick();
    check_st("disc.active1", 4, 1, 1, 1);
    repeat (16) tick();
    check_st("disc.recov_last", 5, 15, 0, 1);
    tick();
    check_st("disc.end", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_st("disc.held", 0, 0, 0, 0);
    end
    btn_attack = 1'b0;

    // Asynchronous reset mid-recovery.
    pulse_attack();
    repeat (15) tick();
    check_st("rst.pre", 5, 7, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_st("rst.async", 0, 0, 0, 0);
    btn_right = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tick();
    check_st("rst.after", 2, 0, 0, 0);
    btn_right = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
